// File: rtl/matmul_ctrl_module.sv
// Matrix-multiply request controller: accepts a request, runs the datapath under
// a watchdog, captures the masked result and holds it until the consumer takes it.
module matmul_ctrl_module #(
   parameter int  DATA_WIDTH = 8,
   parameter int  BUS_WIDTH  = 16,
   parameter int  TIMEOUT    = 32,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   localparam int OP_W       = MAX_DIM * MAX_DIM * DATA_WIDTH,
   localparam int C_W        = 2 * OP_W,
   localparam int FL_W       = MAX_DIM * MAX_DIM
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      n_dim_i,
   input  logic [2:0]      k_dim_i,
   input  logic [2:0]      m_dim_i,
   input  logic [OP_W-1:0] a_matrix_i,
   input  logic [OP_W-1:0] b_matrix_i,
   output logic            mm_start_o,
   output logic [2:0]      mm_n_dim_o,
   output logic [2:0]      mm_k_dim_o,
   output logic [2:0]      mm_m_dim_o,
   output logic [OP_W-1:0] mm_a_matrix_o,
   output logic [OP_W-1:0] mm_b_matrix_o,
   input  logic            mm_finish_i,
   input  logic [C_W-1:0]  mm_c_matrix_i,
   input  logic [FL_W-1:0] mm_flags_i,
   output logic            res_valid_o,
   input  logic            res_ready_i,
   output logic [C_W-1:0]  c_matrix_o,
   output logic [FL_W-1:0] flags_o,
   output logic            ovf_o,
   output logic            err_o,
   output logic            busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]      state_q;
   logic [WD_W-1:0] wd_q;
   logic            dims_ok;
   logic [FL_W-1:0] flag_mask;
   logic [FL_W-1:0] flags_masked;

   function automatic logic dim_ok(input logic [2:0] d);
      return (int'(d) >= 1) && (int'(d) <= MAX_DIM);
   endfunction

   assign dims_ok = dim_ok(n_dim_i) && dim_ok(k_dim_i) && dim_ok(m_dim_i);

   // Only PEs inside the latched N x M result window may report overflow.
   for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
      for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
         assign flag_mask[i + j*MAX_DIM] = (int'(mm_n_dim_o) > i) && (int'(mm_m_dim_o) > j);
      end
   end

   assign flags_masked = mm_flags_i & flag_mask;

   assign req_ready_o = (state_q == IDLE);
   assign mm_start_o  = (state_q == RUN);
   assign res_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         wd_q          <= '0;
         mm_n_dim_o    <= '0;
         mm_k_dim_o    <= '0;
         mm_m_dim_o    <= '0;
         mm_a_matrix_o <= '0;
         mm_b_matrix_o <= '0;
         c_matrix_o    <= '0;
         flags_o       <= '0;
         ovf_o         <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  if (dims_ok) begin
                     mm_n_dim_o    <= n_dim_i;
                     mm_k_dim_o    <= k_dim_i;
                     mm_m_dim_o    <= m_dim_i;
                     mm_a_matrix_o <= a_matrix_i;
                     mm_b_matrix_o <= b_matrix_i;
                     wd_q          <= '0;
                     state_q       <= RUN;
                  end else begin
                     c_matrix_o <= '0;
                     flags_o    <= '0;
                     ovf_o      <= 1'b0;
                     err_o      <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            RUN: begin
               // Finish is tested first so it beats a coincident timeout.
               if (mm_finish_i) begin
                  c_matrix_o <= mm_c_matrix_i;
                  flags_o    <= flags_masked;
                  ovf_o      <= |flags_masked;
                  err_o      <= 1'b0;
                  state_q    <= DONE;
               end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  c_matrix_o <= '0;
                  flags_o    <= '0;
                  ovf_o      <= 1'b0;
                  err_o      <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            DONE: begin
               if (res_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_ctrl_module.sv
// Bench for matmul_ctrl_module: directed and randomized requests checked against
// a behavioural matrix/handshake model, with the bench acting as the datapath.
module tb_matmul_ctrl_module;

   localparam int DW      = 8;
   localparam int MAXD    = 2;
   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  n_dim_i, k_dim_i, m_dim_i;
   logic [31:0] a_matrix_i, b_matrix_i;
   logic        mm_start_o;
   logic [2:0]  mm_n_dim_o, mm_k_dim_o, mm_m_dim_o;
   logic [31:0] mm_a_matrix_o, mm_b_matrix_o;
   logic        mm_finish_i;
   logic [63:0] mm_c_matrix_i;
   logic [3:0]  mm_flags_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [63:0] c_matrix_o;
   logic [3:0]  flags_o;
   logic        ovf_o, err_o, busy_o;

   int n_checks = 0;
   int n_fails  = 0;

   matmul_ctrl_module #(.DATA_WIDTH(DW), .BUS_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
      .a_matrix_i(a_matrix_i), .b_matrix_i(b_matrix_i),
      .mm_start_o(mm_start_o),
      .mm_n_dim_o(mm_n_dim_o), .mm_k_dim_o(mm_k_dim_o), .mm_m_dim_o(mm_m_dim_o),
      .mm_a_matrix_o(mm_a_matrix_o), .mm_b_matrix_o(mm_b_matrix_o),
      .mm_finish_i(mm_finish_i), .mm_c_matrix_i(mm_c_matrix_i), .mm_flags_i(mm_flags_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .c_matrix_o(c_matrix_o), .flags_o(flags_o),
      .ovf_o(ovf_o), .err_o(err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic dims_valid(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m);
      return (n >= 1 && n <= MAXD) && (k >= 1 && k <= MAXD) && (m >= 1 && m <= MAXD);
   endfunction

   // Reference datapath: C = A x B over the active N x K x M window, 16-bit elements.
   function automatic logic [63:0] matmul(input logic [31:0] a, input logic [31:0] b,
                                          input int n, input int k, input int m);
      logic [63:0] c;
      int unsigned acc;
      c = '0;
      for (int r = 0; r < n; r++) begin
         for (int col = 0; col < m; col++) begin
            acc = 0;
            for (int x = 0; x < k; x++)
               acc += int'(a[(r*MAXD + x)*DW +: DW]) * int'(b[(x*MAXD + col)*DW +: DW]);
            c[(r*MAXD + col)*16 +: 16] = acc[15:0];
         end
      end
      return c;
   endfunction

   function automatic logic [3:0] mask_flags(input logic [3:0] flg, input int n, input int m);
      logic [3:0] f;
      f = '0;
      for (int i = 0; i < MAXD; i++)
         for (int j = 0; j < MAXD; j++)
            if (i < n && j < m) f[i + j*MAXD] = flg[i + j*MAXD];
      return f;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_start"}, 64'(mm_start_o), 64'd0);
      check({tag, "_rvalid"}, 64'(res_valid_o), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
      check({tag, "_ovf"}, 64'(ovf_o), 64'd0);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
      check({tag, "_c"}, c_matrix_o, 64'd0);
      check({tag, "_flags"}, 64'(flags_o), 64'd0);
      check({tag, "_dims"}, 64'({mm_n_dim_o, mm_k_dim_o, mm_m_dim_o}), 64'd0);
      check({tag, "_ab"}, {mm_a_matrix_o, mm_b_matrix_o}, 64'd0);
   endtask

   // One full transaction. fin_cycle is the RUN cycle (1-based) on which the bench
   // datapath raises finish; outside 1..TIMEOUT the watchdog must fire instead.
   task automatic do_op(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] flg,
                        input int fin_cycle, input int stall,
                        input bit use_ref, input logic [63:0] c_ref);
      logic        valid;
      logic [63:0] c_dp, c_exp;
      logic [3:0]  f_exp;
      logic        e_exp;
      valid = dims_valid(n, k, m);
      c_dp  = matmul(a, b, int'(n), int'(k), int'(m));

      check("idle_ready", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1;
      n_dim_i = n; k_dim_i = k; m_dim_i = m;
      a_matrix_i = a; b_matrix_i = b;
      tick;
      req_valid_i = 1'b0;
      a_matrix_i = $urandom; b_matrix_i = $urandom;
      n_dim_i = 3'($urandom); k_dim_i = 3'($urandom); m_dim_i = 3'($urandom);

      if (!valid) begin
         c_exp = '0; f_exp = '0; e_exp = 1'b1;
      end else begin
         for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            check("run_start", 64'(mm_start_o), 64'd1);
            check("run_ready", 64'(req_ready_o), 64'd0);
            check("run_busy", 64'(busy_o), 64'd1);
            if (cyc == 1) begin
               check("latched_dims", 64'({mm_n_dim_o, mm_k_dim_o, mm_m_dim_o}), 64'({n, k, m}));
               check("latched_ab", {mm_a_matrix_o, mm_b_matrix_o}, {a, b});
            end
            if (cyc == fin_cycle) begin
               mm_finish_i = 1'b1; mm_c_matrix_i = c_dp; mm_flags_i = flg;
            end
            tick;
            mm_finish_i = 1'b0;
            mm_c_matrix_i = {$urandom, $urandom};
            mm_flags_i = 4'($urandom);
            if (cyc == fin_cycle) break;
         end
         if (fin_cycle >= 1 && fin_cycle <= TIMEOUT) begin
            c_exp = c_dp; f_exp = mask_flags(flg, int'(n), int'(m)); e_exp = 1'b0;
         end else begin
            c_exp = '0; f_exp = '0; e_exp = 1'b1;
         end
      end

      for (int s = 0; s <= stall; s++) begin
         check("done_rvalid", 64'(res_valid_o), 64'd1);
         check("done_start", 64'(mm_start_o), 64'd0);
         check("done_ready", 64'(req_ready_o), 64'd0);
         check("done_busy", 64'(busy_o), 64'd1);
         check("done_c", c_matrix_o, c_exp);
         check("done_flags", 64'(flags_o), 64'(f_exp));
         check("done_ovf", 64'(ovf_o), 64'(|f_exp));
         check("done_err", 64'(err_o), 64'(e_exp));
         if (use_ref) check("done_c_ref", c_matrix_o, c_ref);
         if (s < stall) begin
            // stray finish and requests while a result is pending must be ignored
            res_ready_i = 1'b0;
            mm_finish_i = 1'($urandom);
            mm_c_matrix_i = {$urandom, $urandom};
            mm_flags_i = 4'hF;
            req_valid_i = 1'b1;
            n_dim_i = 3'd1; k_dim_i = 3'd1; m_dim_i = 3'd1;
            tick;
            mm_finish_i = 1'b0;
            req_valid_i = 1'b0;
         end
      end
      res_ready_i = 1'b1;
      tick;
      res_ready_i = 1'b0;
      check("post_rvalid", 64'(res_valid_o), 64'd0);
      check("post_ready", 64'(req_ready_o), 64'd1);
      check("post_busy", 64'(busy_o), 64'd0);
      check("post_start", 64'(mm_start_o), 64'd0);
      if (valid) check("hold_ab", {mm_a_matrix_o, mm_b_matrix_o}, {a, b});
   endtask

   initial begin
      logic [2:0] rn, rk, rm;
      rst_i = 1'b1; req_valid_i = 1'b0; res_ready_i = 1'b0;
      n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
      a_matrix_i = '0; b_matrix_i = '0;
      mm_finish_i = 1'b0; mm_c_matrix_i = '0; mm_flags_i = '0;
      tick; tick;
      check_reset_state("reset");
      rst_i = 1'b0;
      tick;
      check("reset_release_ready", 64'(req_ready_o), 64'd1);

      // finish pulse while idle is ignored
      mm_finish_i = 1'b1; mm_c_matrix_i = 64'hDEAD_BEEF_0123_4567; mm_flags_i = 4'hF;
      tick;
      mm_finish_i = 1'b0;
      check("idle_finish_busy", 64'(busy_o), 64'd0);
      check("idle_finish_rvalid", 64'(res_valid_o), 64'd0);
      check("idle_finish_c", c_matrix_o, 64'd0);

      // A=[[1,2],[3,4]], B=[[5,6],[7,8]], finish on the 4th RUN cycle, 5-cycle stall
      do_op(3'd2, 3'd2, 3'd2, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
            4'h0, 4, 5, 1'b1, 64'h0032_002B_0016_0013);

      // invalid dimensions
      do_op(3'd0, 3'd2, 3'd2, $urandom, $urandom, 4'h0, 1, 1, 1'b0, '0);
      do_op(3'd3, 3'd2, 3'd2, $urandom, $urandom, 4'h0, 1, 0, 1'b0, '0);
      do_op(3'd2, 3'd0, 3'd1, $urandom, $urandom, 4'h0, 1, 0, 1'b0, '0);
      do_op(3'd1, 3'd1, 3'd7, $urandom, $urandom, 4'h0, 1, 0, 1'b0, '0);

      // overflow masking: N=1, M=2, all PE flags set
      do_op(3'd1, 3'd2, 3'd2, $urandom, $urandom, 4'hF, 3, 0, 1'b0, '0);
      do_op(3'd2, 3'd1, 3'd1, $urandom, $urandom, 4'hF, 1, 1, 1'b0, '0);

      // watchdog: no finish, then finish exactly on the last allowed cycle
      do_op(3'd2, 3'd2, 3'd2, $urandom, $urandom, 4'hF, 0, 1, 1'b0, '0);
      do_op(3'd2, 3'd2, 3'd2, $urandom, $urandom, 4'h3, TIMEOUT, 0, 1'b0, '0);
      do_op(3'd2, 3'd2, 3'd1, $urandom, $urandom, 4'h1, TIMEOUT - 1, 0, 1'b0, '0);

      // leave err_o set, then reset in the middle of RUN
      do_op(3'd1, 3'd1, 3'd1, $urandom, $urandom, 4'h0, 0, 0, 1'b0, '0);
      req_valid_i = 1'b1;
      n_dim_i = 3'd2; k_dim_i = 3'd1; m_dim_i = 3'd2;
      a_matrix_i = 32'hA5A5_5A5A; b_matrix_i = 32'h1234_5678;
      tick;
      req_valid_i = 1'b0;
      check("midrun_start", 64'(mm_start_o), 64'd1);
      tick;
      rst_i = 1'b1;
      tick;
      check_reset_state("midrun_reset");
      rst_i = 1'b0;
      tick;
      check("midrun_release_ready", 64'(req_ready_o), 64'd1);

      // randomized traffic
      for (int t = 0; t < 24; t++) begin
         rn = 3'($urandom_range(0, 3));
         rk = 3'($urandom_range(1, 2));
         rm = 3'($urandom_range(1, 3));
         do_op(rn, rk, rm, $urandom, $urandom, 4'($urandom),
               int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1'b0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/matmul_ctrl_module.md
MATMUL_CTRL_MODULE -- requirements
Module: matmul_ctrl_module

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 Parameter BUS_WIDTH, default 16; MAX_DIM = BUS_WIDTH/DATA_WIDTH (default 2).
REQ-003 Parameter TIMEOUT, default 32, maximum RUN cycles before abort.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock, all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 req_valid_i / req_ready_o  in/out  1  request handshake.
REQ-008 n_dim_i, k_dim_i, m_dim_i  in  3 each  dimensions: A is NxK, B is KxM.
REQ-009 a_matrix_i, b_matrix_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH each  operands, row r word at bit r*MAX_DIM*DATA_WIDTH.
REQ-010 mm_start_o  out  1  start to datapath.
REQ-011 mm_n_dim_o, mm_k_dim_o, mm_m_dim_o  out  3 each  latched dimensions.
REQ-012 mm_a_matrix_o, mm_b_matrix_o  out  operand width  latched operands.
REQ-013 mm_finish_i  in  1  datapath done.
REQ-014 mm_c_matrix_i  in  MAX_DIM*MAX_DIM*2*DATA_WIDTH  datapath result.
REQ-015 mm_flags_i  in  MAX_DIM*MAX_DIM  per-PE overflow, PE(row i, col j) at bit i+j*MAX_DIM.
REQ-016 res_valid_o / res_ready_i  out/in  1  result handshake.
REQ-017 c_matrix_o  out  result width  captured result.
REQ-018 flags_o  out  MAX_DIM*MAX_DIM  captured flags, masked.
REQ-019 ovf_o, err_o, busy_o  out  1 each  any masked overflow; invalid dims or timeout; FSM not IDLE.

Function
REQ-020 FSM states IDLE, RUN, DONE; req_ready_o=1 only in IDLE; busy_o=1 in RUN and DONE.
REQ-021 IDLE, req_valid_i=1: dims each in 1..MAX_DIM -> latch dims and operands, mm_start_o=1 next cycle, go RUN.
REQ-022 IDLE, req_valid_i=1, any dim 0 or >MAX_DIM -> go DONE; c_matrix_o=0, flags_o=0, ovf_o=0, err_o=1; mm_start_o stays 0.
REQ-023 mm_* outputs hold latched values, unchanged from accept until next accept.
REQ-024 RUN: mm_start_o held 1; watchdog increments each cycle from 0 at entry.
REQ-025 RUN, mm_finish_i=1 sampled: capture mm_c_matrix_i into c_matrix_o on that edge; flags_o bit (i+j*MAX_DIM) = mm_flags_i bit AND (i<N) AND (j<M); ovf_o = OR of flags_o; err_o=0; next cycle mm_start_o=0, go DONE.
REQ-026 RUN, watchdog reaches TIMEOUT-1 without mm_finish_i: go DONE, mm_start_o=0, err_o=1, c_matrix_o=0, flags_o=0.
REQ-027 mm_finish_i and timeout in same cycle: finish wins, err_o=0.
REQ-028 DONE: res_valid_o=1, outputs stable until res_ready_i=1 sampled; then IDLE, res_valid_o=0 next cycle.
REQ-029 mm_start_o is 0 in IDLE and DONE, guaranteeing at least one low cycle between operations so the datapath counter and accumulators clear.
REQ-030 mm_finish_i outside RUN is ignored.
REQ-031 Request-to-start latency 1 cycle; finish-to-res_valid_o latency 1 cycle.
REQ-032 No new request accepted before res_ready_i completes the current result; back-to-back ops separated by >=1 IDLE cycle.

Reset
REQ-033 rst_i=1 at a rising edge, in any state including mid-RUN, puts FSM in IDLE; watchdog=0; mm_start_o, res_valid_o, err_o, ovf_o, busy_o=0; c_matrix_o, flags_o, all mm_* data/dim outputs=0; req_ready_o=1 after release.

Verification
REQ-034 N=K=M=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], model finish after 4 RUN cycles -> C elements 19,22,43,50 on c_matrix_o, flags_o=0, err_o=0, res_valid_o 1 until res_ready_i.
REQ-035 n_dim_i=0 or 3 with MAX_DIM=2 -> DONE next cycle, err_o=1, c_matrix_o=0, mm_start_o never 1.
REQ-036 N=1, M=2, mm_flags_i=4'b1111 at finish -> flags_o=4'b0101, ovf_o=1.
REQ-037 mm_finish_i never asserted -> mm_start_o drops after TIMEOUT (32) RUN cycles, err_o=1; finish on that same cycle -> err_o=0.
REQ-038 rst_i asserted mid-RUN -> mm_start_o=0 and IDLE next edge; res_valid_o held with res_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0 throughout.
